// File: rtl/board_pkg.sv
// ---------------------------------------------------------------------------
// board_pkg
//   Shared constants for the 64-cell board memory and its clients.
//   Address layout is {y[2:0], x[2:0]}; the helpers below split an address
//   into its column/row so every client decodes cells the same way.
//   Port-select codes identify which client currently owns the board port.
// ---------------------------------------------------------------------------
package board_pkg;

  localparam int BOARD_ADDR_W = 6;
  localparam int PIECE_W      = 4;
  localparam int BOARD_CELLS  = 64;

  typedef enum logic [1:0] {
    SEL_CONTROL   = 2'd0,
    SEL_VALIDATOR = 2'd1,
    SEL_DATAPATH  = 2'd2,
    SEL_VIEW      = 2'd3
  } port_sel_e;

  function automatic logic [2:0] cell_x(input logic [BOARD_ADDR_W-1:0] a);
    return a[2:0];
  endfunction

  function automatic logic [2:0] cell_y(input logic [BOARD_ADDR_W-1:0] a);
    return a[5:3];
  endfunction

endpackage

// File: rtl/board_read_fifo.sv
// ---------------------------------------------------------------------------
// board_read_fifo
//   Synchronous first-word-fall-through FIFO buffering {addr, piece} records
//   between the board read pipeline and the renderer handshake.
// Ports
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset (pointers and count only)
//   i_push       in   write i_push_data this cycle (caller guarantees space)
//   i_push_data  in   WIDTH-bit record
//   i_pop        in   consume the head record (ignored when empty)
//   o_pop_data   out  head record, valid whenever o_empty is low
//   o_empty      out  no records held
//   o_count      out  number of records held (0..DEPTH)
// ---------------------------------------------------------------------------
module board_read_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop      = i_pop && (r_count != '0);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/board_reader.sv
// ---------------------------------------------------------------------------
// board_reader
//   Read-side client of the shared board memory. A start pulse requests the
//   board port, sweeps cells 0..63, absorbs the RAM read latency with a tag
//   shift register and streams {x, y, piece} to the renderer over
//   valid/ready. Issue is credit-limited so the output FIFO never overflows.
// Ports
//   clk           in   system clock
//   resetn        in   asynchronous active-low reset
//   start         in   1-cycle pulse, begins a sweep when idle
//   grant         in   board port currently routed to address_view
//   piece_read    in   board RAM read data (READ_LATENCY after address)
//   req           out  board port request
//   address_view  out  read address to the board port
//   out_valid     out  out_x/out_y/out_piece hold a cell
//   out_ready     in   renderer accepts the cell this cycle
//   out_x, out_y  out  column/row of the cell
//   out_piece     out  piece code of the cell
//   busy          out  sweep in progress
//   done          out  1-cycle pulse after the last cell is accepted
// ---------------------------------------------------------------------------
module board_reader
  import board_pkg::*;
#(
  parameter int ADDR_W       = BOARD_ADDR_W,
  parameter int DATA_W       = PIECE_W,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              grant,
  input  logic [DATA_W-1:0] piece_read,
  output logic              req,
  output logic [ADDR_W-1:0] address_view,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_x,
  output logic [2:0]        out_y,
  output logic [DATA_W-1:0] out_piece,
  output logic              busy,
  output logic              done
);

  localparam int CELLS  = 1 << ADDR_W;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int FIFO_W = ADDR_W + DATA_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GRANT,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            r_state;
  state_e            w_next;

  // One extra bit so "all 64 issued" is representable without wrapping.
  logic [PTR_W-1:0]  r_issue_ptr;

  logic              r_sr_vld  [READ_LATENCY];
  logic [ADDR_W-1:0] r_sr_addr [READ_LATENCY];

  logic [OCC_W-1:0]  w_inflight;
  logic [OCC_W-1:0]  w_occ;
  logic              w_credit;
  logic              w_fire;
  logic              w_capture;
  logic              w_xfer;
  logic              w_last_xfer;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [FIFO_W-1:0] w_fifo_data;
  logic [ADDR_W-1:0] w_head_addr;

  // ---- credit / issue -----------------------------------------------------
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + OCC_W'(r_sr_vld[i]);
    end
  end

  // Reads already in flight reserve a FIFO slot, so a push can never land on
  // a full FIFO even when the renderer stalls.
  assign w_occ    = OCC_W'(w_fifo_count) + w_inflight;
  assign w_credit = (w_occ < OCC_W'(FIFO_DEPTH));
  assign w_fire   = (r_state == S_ISSUE) && grant &&
                    (r_issue_ptr < PTR_W'(CELLS)) && w_credit;

  assign address_view = r_issue_ptr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_issue_ptr <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_issue_ptr <= '0;
    end else if (w_fire) begin
      r_issue_ptr <= r_issue_ptr + PTR_W'(1);
    end
  end

  // ---- read-latency tag pipeline ------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) r_sr_vld[i] <= 1'b0;
    end else begin
      r_sr_vld[0] <= w_fire;
      for (int i = 1; i < READ_LATENCY; i++) r_sr_vld[i] <= r_sr_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_sr_addr[0] <= r_issue_ptr[ADDR_W-1:0];
    for (int i = 1; i < READ_LATENCY; i++) r_sr_addr[i] <= r_sr_addr[i-1];
  end

  // The tag reaches the last stage in the same cycle piece_read is valid.
  assign w_capture = r_sr_vld[READ_LATENCY-1];

  // ---- output buffer ------------------------------------------------------
  board_read_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_capture),
    .i_push_data ({r_sr_addr[READ_LATENCY-1], piece_read}),
    .i_pop       (w_xfer),
    .o_pop_data  (w_fifo_data),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign out_valid   = !w_fifo_empty;
  assign w_xfer      = out_valid && out_ready;
  assign w_head_addr = w_fifo_data[FIFO_W-1:DATA_W];

  // Zero the payload when nothing is held so the bus is quiet after reset.
  assign out_x     = out_valid ? cell_x(w_head_addr) : 3'd0;
  assign out_y     = out_valid ? cell_y(w_head_addr) : 3'd0;
  assign out_piece = out_valid ? w_fifo_data[DATA_W-1:0] : '0;

  // Last cell leaves when everything has been issued, nothing is in flight
  // and the FIFO holds only the head being accepted.
  assign w_last_xfer = w_xfer && (w_fifo_count == CNT_W'(1)) &&
                       (w_inflight == '0) && (r_issue_ptr == PTR_W'(CELLS));

  // ---- control FSM --------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    req    = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_WAIT_GRANT;
      end
      S_WAIT_GRANT: begin
        req  = 1'b1;
        busy = 1'b1;
        if (grant) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        req  = 1'b1;
        busy = 1'b1;
        if (w_fire && (r_issue_ptr == PTR_W'(CELLS - 1))) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_last_xfer) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_board_reader.sv
// ---------------------------------------------------------------------------
// tb_board_reader
//   Two board_reader instances (READ_LATENCY 1 and 3, FIFO_DEPTH 4) share
//   start/grant/out_ready and each sees its own modelled board RAM. A table of
//   sweep scenarios is applied in a loop; reset-mid-sweep is hand-written.
// ---------------------------------------------------------------------------
module tb_board_reader;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       grant;
  logic       out_ready;

  logic [3:0] piece   [2];
  logic       req     [2];
  logic [5:0] addr    [2];
  logic       ov      [2];
  logic [2:0] ox      [2];
  logic [2:0] oy      [2];
  logic [3:0] op      [2];
  logic       busy    [2];
  logic       done_o  [2];

  logic [3:0] mem [64];
  logic [3:0] p_l1, p_l3a, p_l3b, p_l3c;

  always #5 clk = ~clk;

  board_reader #(.READ_LATENCY(1), .FIFO_DEPTH(4)) u_dut_l1 (
    .clk(clk), .resetn(resetn), .start(start), .grant(grant),
    .piece_read(piece[0]), .req(req[0]), .address_view(addr[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_x(ox[0]), .out_y(oy[0]),
    .out_piece(op[0]), .busy(busy[0]), .done(done_o[0])
  );

  board_reader #(.READ_LATENCY(3), .FIFO_DEPTH(4)) u_dut_l3 (
    .clk(clk), .resetn(resetn), .start(start), .grant(grant),
    .piece_read(piece[1]), .req(req[1]), .address_view(addr[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_x(ox[1]), .out_y(oy[1]),
    .out_piece(op[1]), .busy(busy[1]), .done(done_o[1])
  );

  // Board RAM models: data appears 1 or 3 cycles after the address.
  always @(posedge clk) begin
    p_l1  <= mem[addr[0]];
    p_l3a <= mem[addr[1]];
    p_l3b <= p_l3a;
    p_l3c <= p_l3b;
  end
  assign piece[0] = p_l1;
  assign piece[1] = p_l3c;

  typedef struct {
    int stall_at;    // beat count (DUT0) where out_ready drops, -1 none
    int stall_len;
    int gd_at;       // cycle after start where grant drops, -1 none
    int gd_len;
    int restart_at;  // beat count where a stray start is pulsed, -1 none
    bit sod;         // pulse start in DUT0's done cycle
    int mul;         // board content: cell k = (k*mul+off)%16
    int off;
    int exp_beats;
    int exp_dones;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         beats     [2];
  int         dones     [2];
  int         first_iss [2];
  int         first_v   [2];
  logic       last63    [2];
  logic       prev_v    [2];
  logic [9:0] prev_dat  [2];
  logic       prev_busy [2];
  logic [5:0] prev_addr [2];
  logic       prev_g;
  logic       prev_r;

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, d, act, exp);
    end
  endtask

  function automatic int rl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic fill_mem(input int mul, input int off);
    for (int k = 0; k < 64; k++) mem[k] = 4'((k * mul + off) % 16);
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      beats[d] = 0; dones[d] = 0; first_iss[d] = -1; first_v[d] = -1;
      last63[d] = 1'b0; prev_v[d] = 1'b0; prev_dat[d] = '0;
      prev_busy[d] = 1'b0; prev_addr[d] = '0;
    end
    prev_g = 1'b1;
    prev_r = 1'b1;
  endtask

  // Called at the falling edge: checks this cycle's DUT outputs.
  task automatic check_cycle();
    logic [5:0] kk;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (prev_v[d] && !prev_r) begin
        chk("hold_valid", d, 32'(ov[d]), 32'd1);
        chk("hold_data", d, 32'({ox[d], oy[d], op[d]}), 32'(prev_dat[d]));
      end
      if (prev_busy[d] && busy[d] && !prev_g)
        chk("addr_freeze", d, 32'(addr[d]), 32'(prev_addr[d]));
      if (first_iss[d] < 0 && busy[d] && addr[d] == 6'd1) first_iss[d] = cyc;
      if (ov[d] && first_v[d] < 0) begin
        first_v[d] = cyc;
        chk("first_valid_latency", d,
            32'(first_iss[d] >= 0 && (first_v[d] - first_iss[d]) >= rl(d)), 32'd1);
      end
      if (done_o[d]) begin
        dones[d]++;
        chk("done_after_last", d, 32'({beats[d] == 64, last63[d]}), 32'd3);
      end
      last63[d] = 1'b0;
      if (ov[d] && out_ready) begin
        if (beats[d] < 64) begin
          kk = beats[d][5:0];
          chk("beat", d, 32'({ox[d], oy[d], op[d]}), 32'({kk[2:0], kk[5:3], mem[kk]}));
        end else begin
          chk("extra_beat", d, 32'(beats[d]), 32'd63);
        end
        last63[d] = (beats[d] == 63);
        beats[d]++;
      end
      prev_v[d]    = ov[d];
      prev_dat[d]  = {ox[d], oy[d], op[d]};
      prev_busy[d] = busy[d];
      prev_addr[d] = addr[d];
    end
    prev_g = grant;
    prev_r = out_ready;
  endtask

  task automatic run_vec(input vec_t v);
    int  extra;
    int  stall_cnt;
    bit  stalled;
    bit  restarted;
    fill_mem(v.mul, v.off);
    clear_mon();
    extra = 0; stall_cnt = 0; stalled = 0; restarted = 0;
    for (int j = 0; j < 1500 && extra < 5; j++) begin
      @(posedge clk); #1;
      start = (j == 0);
      if (v.restart_at >= 0 && !restarted && beats[0] >= v.restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (v.sod && done_o[0]) start = 1'b1;
      grant = !(v.gd_at >= 0 && j >= v.gd_at && j < v.gd_at + v.gd_len);
      if (!stalled && v.stall_at >= 0 && beats[0] >= v.stall_at) begin
        stalled = 1;
        stall_cnt = v.stall_len;
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        if (stall_cnt == 1) begin
          for (int d = 0; d < 2; d++)
            chk("stall_occupancy", d, 32'(int'(addr[d]) - beats[d]), 32'd4);
        end
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      check_cycle();
      if (dones[0] > 0 && dones[1] > 0) extra++;
    end
    chk("sweep_finished", 0, 32'(extra >= 5), 32'd1);
    for (int d = 0; d < 2; d++) begin
      chk("beat_total", d, 32'(beats[d]), 32'(v.exp_beats));
      chk("done_total", d, 32'(dones[d]), 32'(v.exp_dones));
      chk("idle_busy", d, 32'(busy[d]), 32'd0);
      chk("idle_req", d, 32'(req[d]), 32'd0);
    end
    start = 1'b0; grant = 1'b1; out_ready = 1'b1;
  endtask

  vec_t vecs [5];

  initial begin
    //           stall      gdrop     rst  sod mul off beats dones
    vecs[0] = '{-1,  0,    -1, 0,    -1,  0,  1,  0,  64,  1};
    vecs[1] = '{10, 20,    -1, 0,    -1,  0,  1,  0,  64,  1};
    vecs[2] = '{-1,  0,    12, 5,    -1,  0,  1,  0,  64,  1};
    vecs[3] = '{-1,  0,    -1, 0,     5,  1,  1,  0,  64,  1};
    vecs[4] = '{40,  7,    30, 3,    -1,  0,  5,  3,  64,  1};

    resetn = 1'b0; start = 1'b0; grant = 1'b1; out_ready = 1'b1;
    fill_mem(1, 0);
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("reset_state", d,
          32'({req[d], addr[d], ov[d], ox[d], oy[d], op[d], busy[d], done_o[d]}), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset asserted at beat 30 abandons the sweep without a done pulse.
    fill_mem(1, 0);
    clear_mon();
    for (int j = 0; j < 500 && beats[0] < 30; j++) begin
      @(posedge clk); #1;
      start = (j == 0); grant = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check_cycle();
    end
    start = 1'b0;
    chk("reached_beat30", 0, 32'(beats[0]), 32'd30);
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk("midsweep_reset", d,
          32'({req[d], addr[d], ov[d], ox[d], oy[d], op[d], busy[d], done_o[d]}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_mon();
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_cycle();
    end
    for (int d = 0; d < 2; d++) begin
      chk("no_done_after_reset", d, 32'(dones[d]), 32'd0);
      chk("idle_after_reset", d, 32'(busy[d]), 32'd0);
    end
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
